// File: rtl/rgmii_rx_inband_status.sv
// RGMII in-band status decoder: tracks RXD during inter-frame gaps, debounces the
// link/speed/duplex code and commits one-hot status flags in the RX clock domain.
//
// state    | meaning
// S_FRAME  | frame or error in progress (or just reset); waiting for the first idle sample
// S_SETTLE | discarding the first idle samples after a frame
// S_TRACK  | tracking idle samples and counting identical consecutive codes
module rgmii_rx_inband_status #(
    parameter int unsigned STABLE_COUNT = 8,
    parameter int unsigned IFG_SETTLE   = 2,
    parameter int unsigned STALE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_dv,
    input  logic       rx_err,
    input  logic [3:0] rxd,
    output logic       rx_speed_10,
    output logic       rx_speed_100,
    output logic       rx_speed_1000,
    output logic       rx_link_up,
    output logic       rx_full_duplex,
    output logic       status_valid,
    output logic       status_change,
    output logic [7:0] bad_code_count
);

    localparam int unsigned RUN_W    = $clog2(STABLE_COUNT + 1);
    localparam int unsigned SETTLE_W = $clog2(IFG_SETTLE + 1);
    localparam int unsigned STALE_W  = (STALE_CYCLES > 0) ? $clog2(STALE_CYCLES + 1) : 1;

    localparam logic [RUN_W-1:0]    RUN_MAX     = RUN_W'(STABLE_COUNT);
    localparam logic [RUN_W-1:0]    RUN_LAST    = RUN_W'(STABLE_COUNT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(IFG_SETTLE - 1);
    localparam logic [STALE_W-1:0]  STALE_MAX   = STALE_W'(STALE_CYCLES);
    localparam logic [STALE_W-1:0]  STALE_LAST  = STALE_W'(STALE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_FRAME,
        S_SETTLE,
        S_TRACK
    } state_t;

    state_t              state;
    logic [RUN_W-1:0]    run;
    logic [3:0]          cand;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [STALE_W-1:0]  stale_cnt;

    logic       sample_ok;
    logic       match;
    logic       commit;
    logic [2:0] speed_hot;
    logic [4:0] new_status;
    logic [4:0] cur_status;

    always_comb begin
        sample_ok = !rx_dv && !rx_err;
        match     = (run != '0) && (rxd == cand);
        commit    = sample_ok && (state == S_TRACK) && match && (run == RUN_LAST);
        speed_hot = 3'b000;
        case (rxd[2:1])
            2'b00:   speed_hot = 3'b100;
            2'b01:   speed_hot = 3'b010;
            2'b10:   speed_hot = 3'b001;
            default: speed_hot = 3'b000;
        endcase
        new_status = {speed_hot, rxd[0], rxd[3]};
        cur_status = {rx_speed_10, rx_speed_100, rx_speed_1000, rx_link_up, rx_full_duplex};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_FRAME;
            run            <= '0;
            cand           <= '0;
            settle_cnt     <= '0;
            stale_cnt      <= '0;
            rx_speed_10    <= 1'b0;
            rx_speed_100   <= 1'b0;
            rx_speed_1000  <= 1'b0;
            rx_link_up     <= 1'b0;
            rx_full_duplex <= 1'b0;
            status_valid   <= 1'b0;
            status_change  <= 1'b0;
            bad_code_count <= '0;
        end else begin
            status_change <= 1'b0;
            if (!sample_ok) begin
                state <= S_FRAME;
                run   <= '0;
                // Stale fires once on reaching the limit; the counter then parks there.
                if (STALE_CYCLES != 0 && stale_cnt != STALE_MAX) begin
                    stale_cnt <= stale_cnt + 1'b1;
                    if (stale_cnt == STALE_LAST) begin
                        status_valid  <= 1'b0;
                        rx_link_up    <= 1'b0;
                        status_change <= rx_link_up;
                    end
                end
            end else begin
                stale_cnt <= '0;
                case (state)
                    S_FRAME: begin
                        settle_cnt <= SETTLE_W'(1);
                        state      <= (IFG_SETTLE == 1) ? S_TRACK : S_SETTLE;
                    end
                    S_SETTLE: begin
                        settle_cnt <= settle_cnt + 1'b1;
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= S_TRACK;
                        end
                    end
                    S_TRACK: begin
                        if (match) begin
                            if (run != RUN_MAX) begin
                                run <= run + 1'b1;
                            end
                        end else begin
                            cand <= rxd;
                            run  <= RUN_W'(1);
                        end
                        if (commit) begin
                            if (rxd[2:1] == 2'b11) begin
                                if (bad_code_count != 8'hff) begin
                                    bad_code_count <= bad_code_count + 1'b1;
                                end
                            end else begin
                                {rx_speed_10, rx_speed_100, rx_speed_1000} <= speed_hot;
                                rx_link_up     <= rxd[0];
                                rx_full_duplex <= rxd[3];
                                status_valid   <= 1'b1;
                                status_change  <= (new_status != cur_status) || !status_valid;
                            end
                        end
                    end
                    default: state <= S_FRAME;
                endcase
            end
        end
    end

endmodule
